// File: rtl/encoder_pkg.sv
// rtl/encoder_pkg.sv - shared constants and event type for the encoder event scheduler
package encoder_pkg;
    localparam int NCH           = 4;
    localparam int WIDTH         = 8;
    localparam int CHAN_W        = 2;
    localparam int IRQ_LEVEL_DEF = 1;

    typedef struct packed {
        logic [CHAN_W-1:0] chan;
        logic [WIDTH-1:0]  delta;
    } enc_event_t;
endpackage

// File: rtl/enc_event_fifo.sv
// rtl/enc_event_fifo.sv - synchronous event FIFO allowing push+pop while full
module enc_event_fifo
    import encoder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  enc_event_t             push_data_i,
    input  logic                   pop_i,
    output enc_event_t             head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    enc_event_t     mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [AW:0]    count_q;
    logic           push_ok;
    logic           pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign pop_ok  = pop_i && !empty_o;
    // When full, a concurrent pop frees the slot the write lands in.
    assign push_ok = push_i && (!full_o || pop_ok);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;
endmodule

// File: rtl/encoder_event_scheduler.sv
// rtl/encoder_event_scheduler.sv - turns encoder count changes into queued {channel, delta} events
module encoder_event_scheduler
    import encoder_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int IRQ_LEVEL = IRQ_LEVEL_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCH*WIDTH-1:0]   enc_values,
    input  logic [NCH-1:0]         chan_mask,
    input  logic                   pop,
    input  logic                   clr_stall,
    output logic                   ev_valid,
    output logic [CHAN_W-1:0]      ev_chan,
    output logic [WIDTH-1:0]       ev_delta,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   stall,
    output logic                   irq
);
    logic [WIDTH-1:0]  enc     [NCH];
    logic [WIDTH-1:0]  snap_q  [NCH];
    logic [WIDTH-1:0]  snap_d  [NCH];
    logic [CHAN_W-1:0] rr_ptr_q, rr_ptr_d;
    logic              stall_q, stall_d;
    logic [NCH-1:0]    pending;
    logic              any_pend;
    logic [CHAN_W-1:0] grant;
    logic              full, empty, pop_eff, push;
    enc_event_t        new_ev, head;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            enc[i]     = enc_values[i*WIDTH +: WIDTH];
            pending[i] = chan_mask[i] && (enc[i] != snap_q[i]);
        end
    end

    // Rotating priority: scan from rr_ptr upwards, first pending channel wins.
    always_comb begin : grant_scan
        logic [CHAN_W-1:0] idx;
        any_pend = 1'b0;
        grant    = '0;
        idx      = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = rr_ptr_q + CHAN_W'(k);
            if (!any_pend && pending[idx]) begin
                any_pend = 1'b1;
                grant    = idx;
            end
        end
    end

    assign pop_eff      = pop && ev_valid;
    assign push         = any_pend && (!full || pop_eff);
    assign new_ev.chan  = grant;
    assign new_ev.delta = enc[grant] - snap_q[grant];

    // A blocked push leaves snap alone so motion keeps accumulating in the delta.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            snap_d[i] = snap_q[i];
            if (!chan_mask[i] || (push && grant == CHAN_W'(i))) snap_d[i] = enc[i];
        end
        rr_ptr_d = push ? grant + CHAN_W'(1) : rr_ptr_q;
        stall_d  = stall_q;
        if (any_pend && full && !pop_eff) stall_d = 1'b1;
        else if (clr_stall)               stall_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) snap_q[i] <= '0;
            rr_ptr_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) snap_q[i] <= snap_d[i];
            rr_ptr_q <= rr_ptr_d;
            stall_q  <= stall_d;
        end
    end

    enc_event_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (new_ev),
        .pop_i       (pop_eff),
        .head_o      (head),
        .full_o      (full),
        .empty_o     (empty),
        .count_o     (fifo_count)
    );

    assign ev_valid = !empty;
    assign ev_chan  = head.chan;
    assign ev_delta = head.delta;
    assign stall    = stall_q;
    assign irq      = int'(fifo_count) >= IRQ_LEVEL;
endmodule
